// File: rtl/color_centroid_tracker.sv
// Color centroid tracker: accumulates per-color coordinate sums over a raster
// frame, then divides them with one shared restoring divider and hands each
// color's centroid to the consumer through a valid/ready handshake.
module color_centroid_tracker #(
  parameter int NUM_COLORS = 3,
  parameter int LABEL_W    = 2,
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int MIN_COUNT  = 16
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [LABEL_W-1:0]                    label_in,
  input  logic                                  label_valid_in,
  input  logic                                  frame_done_in,
  input  logic                                  centroid_ready_in,
  output logic                                  centroid_valid_out,
  output logic [LABEL_W-1:0]                    centroid_color_out,
  output logic [$clog2(FRAME_W)-1:0]            centroid_x_out,
  output logic [$clog2(FRAME_H)-1:0]            centroid_y_out,
  output logic                                  centroid_found_out,
  output logic [$clog2(FRAME_W*FRAME_H+1)-1:0]  pixel_count_out,
  output logic                                  busy_out,
  output logic                                  overflow_out,
  output logic                                  dropped_out
);
  localparam int XW    = $clog2(FRAME_W);
  localparam int YW    = $clog2(FRAME_H);
  localparam int YCW   = $clog2(FRAME_H+1);   // y may reach FRAME_H = frame full
  localparam int CW    = $clog2(FRAME_W*FRAME_H+1);
  localparam int SUM_W = $clog2(FRAME_W*FRAME_H*(FRAME_W-1)+1);
  localparam int SW    = $clog2(SUM_W);

  typedef enum logic [1:0] {ACCUM, DIVIDE, OUTPUT} state_t;
  typedef enum logic [1:0] {P_LOAD, P_X, P_Y} phase_t;

  state_t state, state_n;
  phase_t phase;

  logic [XW-1:0]    x;
  logic [YCW-1:0]   y;
  logic [SUM_W-1:0] sum_x [NUM_COLORS];
  logic [SUM_W-1:0] sum_y [NUM_COLORS];
  logic [CW-1:0]    count [NUM_COLORS];
  logic [LABEL_W-1:0] cur, ci, li;
  logic [CW-1:0]    dvs, rem, rem_n;
  logic [SUM_W-1:0] quo, quo_n;
  logic [CW:0]      rem_sh;
  logic [SW-1:0]    step;
  logic             in_range, lbl_ok, skip, last_step;

  assign in_range  = (y != YCW'(FRAME_H));
  assign lbl_ok    = (label_in != '0) && (label_in <= LABEL_W'(NUM_COLORS));
  assign li        = label_in - 1'b1;
  assign ci        = cur - 1'b1;
  assign skip      = (count[ci] == '0) || (count[ci] < CW'(MIN_COUNT));
  assign last_step = (step == SW'(SUM_W-1));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh = {rem, quo[SUM_W-1]};
    if (rem_sh >= {1'b0, dvs}) begin
      rem_n = rem_sh[CW-1:0] - dvs;
      quo_n = {quo[SUM_W-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[CW-1:0];
      quo_n = {quo[SUM_W-2:0], 1'b0};
    end
  end

  // State register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= ACCUM;
    else          state <= state_n;
  end

  // Next-state and status outputs
  always_comb begin
    state_n            = state;
    busy_out           = 1'b0;
    centroid_valid_out = 1'b0;
    case (state)
      ACCUM:  if (frame_done_in) state_n = DIVIDE;
      DIVIDE: begin
        busy_out = 1'b1;
        if ((phase == P_LOAD && skip) || (phase == P_Y && last_step)) state_n = OUTPUT;
      end
      OUTPUT: begin
        busy_out           = 1'b1;
        centroid_valid_out = 1'b1;
        if (centroid_ready_in)
          state_n = (cur == LABEL_W'(NUM_COLORS)) ? ACCUM : DIVIDE;
      end
      default: state_n = ACCUM;
    endcase
  end

  // Raster position and overflow tracking; runs in every state
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      x            <= '0;
      y            <= '0;
      overflow_out <= 1'b0;
      dropped_out  <= 1'b0;
    end else begin
      dropped_out <= frame_done_in && (state != ACCUM);
      if (frame_done_in) begin
        x            <= '0;
        y            <= '0;
        overflow_out <= 1'b0;
      end else if (label_valid_in) begin
        if (!in_range)                  overflow_out <= 1'b1;
        else if (x == XW'(FRAME_W-1)) begin
          x <= '0;
          y <= y + 1'b1;
        end else                        x <= x + 1'b1;
      end
    end
  end

  // Accumulators, divider sequencing and result registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
        count[i] <= '0;
      end
      phase              <= P_LOAD;
      cur                <= LABEL_W'(1);
      dvs                <= '0;
      rem                <= '0;
      quo                <= '0;
      step               <= '0;
      centroid_color_out <= '0;
      centroid_x_out     <= '0;
      centroid_y_out     <= '0;
      centroid_found_out <= 1'b0;
      pixel_count_out    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          // A pixel coinciding with frame_done still belongs to the ending frame
          if (label_valid_in && in_range && lbl_ok) begin
            sum_x[li] <= sum_x[li] + SUM_W'(x);
            sum_y[li] <= sum_y[li] + SUM_W'(y);
            count[li] <= count[li] + 1'b1;
          end
          if (frame_done_in) begin
            cur   <= LABEL_W'(1);
            phase <= P_LOAD;
          end
        end
        DIVIDE: begin
          case (phase)
            P_LOAD: begin
              if (skip) begin
                centroid_color_out <= cur;
                centroid_x_out     <= '0;
                centroid_y_out     <= '0;
                centroid_found_out <= 1'b0;
                pixel_count_out    <= count[ci];
              end else begin
                dvs   <= count[ci];
                rem   <= '0;
                quo   <= sum_x[ci];
                step  <= '0;
                phase <= P_X;
              end
            end
            P_X: begin
              if (last_step) begin
                centroid_x_out <= quo_n[XW-1:0];
                rem            <= '0;
                quo            <= sum_y[ci];
                step           <= '0;
                phase          <= P_Y;
              end else begin
                rem  <= rem_n;
                quo  <= quo_n;
                step <= step + 1'b1;
              end
            end
            P_Y: begin
              if (last_step) begin
                centroid_y_out     <= quo_n[YW-1:0];
                centroid_color_out <= cur;
                centroid_found_out <= 1'b1;
                pixel_count_out    <= dvs;
                phase              <= P_LOAD;
              end else begin
                rem  <= rem_n;
                quo  <= quo_n;
                step <= step + 1'b1;
              end
            end
            default: phase <= P_LOAD;
          endcase
        end
        OUTPUT: begin
          if (centroid_ready_in) begin
            phase <= P_LOAD;
            if (cur == LABEL_W'(NUM_COLORS)) begin
              for (int i = 0; i < NUM_COLORS; i++) begin
                sum_x[i] <= '0;
                sum_y[i] <= '0;
                count[i] <= '0;
              end
            end else begin
              cur <= cur + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_color_centroid_tracker.sv
// Scoreboard bench: directed frames push expected centroids, a negedge monitor
// pops and compares on every valid/ready handshake.
module tb_color_centroid_tracker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] label = '0;
  logic       lvalid = 1'b0, fdone = 1'b0, ready = 1'b1;
  logic       cvalid, found, busy, ovf, dropped;
  logic [1:0] color, cy;
  logic [2:0] cx;
  logic [5:0] cnt;

  int checks = 0, errors = 0, drop_cnt = 0;

  typedef struct {int c; int x; int y; int f; int n;} exp_t;
  exp_t sb[$];
  logic [1:0] pix[33];

  color_centroid_tracker #(.NUM_COLORS(3), .LABEL_W(2), .FRAME_W(8), .FRAME_H(4), .MIN_COUNT(2)) dut (
    .clk_in(clk), .reset_in(rst), .label_in(label), .label_valid_in(lvalid),
    .frame_done_in(fdone), .centroid_ready_in(ready), .centroid_valid_out(cvalid),
    .centroid_color_out(color), .centroid_x_out(cx), .centroid_y_out(cy),
    .centroid_found_out(found), .pixel_count_out(cnt), .busy_out(busy),
    .overflow_out(ovf), .dropped_out(dropped));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted result against the scoreboard head
  always @(negedge clk) begin
    if (!rst && dropped) drop_cnt++;
    if (!rst && cvalid && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: got color %0d x %0d y %0d found %0d count %0d, expected none",
                 color, cx, cy, found, cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (color != e.c || cx != e.x || cy != e.y || found != e.f || cnt != e.n) begin
          errors++;
          $display("FAIL result_c%0d: got color %0d x %0d y %0d found %0d count %0d, expected color %0d x %0d y %0d found %0d count %0d",
                   e.c, color, cx, cy, found, cnt, e.c, e.x, e.y, e.f, e.n);
        end
      end
    end
  end

  task automatic push(input int c, input int x, input int y, input int f, input int n);
    exp_t e;
    e.c = c; e.x = x; e.y = y; e.f = f; e.n = n;
    sb.push_back(e);
  endtask

  task automatic clear_pix();
    for (int i = 0; i < 33; i++) pix[i] = 2'd0;
  endtask

  task automatic send_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      lvalid = 1'b1;
      label  = pix[i];
      @(posedge clk); #1;
    end
    lvalid = 1'b0;
    label  = '0;
  endtask

  task automatic pulse_done();
    fdone = 1'b1;
    @(posedge clk); #1;
    fdone = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle_timeout"}, busy, 0);
  endtask

  task automatic frame_a();
    clear_pix();
    pix[10] = 2'd1; pix[12] = 2'd1; pix[19] = 2'd1;
  endtask

  task automatic push_a();
    push(1, 3, 1, 1, 3); push(2, 0, 0, 0, 0); push(3, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    int d0;
    #2;
    chk("rst_valid", cvalid, 0); chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);      chk("rst_dropped", dropped, 0);
    chk("rst_x", cx, 0);         chk("rst_count", cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic three-pixel centroid
    frame_a(); push_a();
    send_pixels(32); pulse_done(); wait_idle("basic");

    // Single pixel below MIN_COUNT, then two pixels above it
    clear_pix(); pix[31] = 2'd3;
    push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0); push(3, 0, 0, 0, 1);
    send_pixels(32); pulse_done(); wait_idle("single");
    clear_pix(); pix[29] = 2'd3; pix[31] = 2'd3;
    push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0); push(3, 6, 3, 1, 2);
    send_pixels(32); pulse_done(); wait_idle("pair");

    // Back-pressure: outputs held stable while ready is low
    frame_a(); push_a();
    send_pixels(32);
    ready = 1'b0;
    pulse_done();
    n = 0;
    while (!cvalid && n < 200) begin @(posedge clk); #1; n++; end
    chk("bp_valid_timeout", cvalid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", cvalid, 1); chk("bp_color", color, 1);
      chk("bp_x", cx, 3); chk("bp_y", cy, 1); chk("bp_count", cnt, 3);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_idle("bp");

    // frame_done during DIVIDE is dropped, results unaffected
    d0 = drop_cnt;
    frame_a(); push_a();
    send_pixels(32); pulse_done();
    repeat (2) begin @(posedge clk); #1; end
    chk("drop_in_divide", busy && !cvalid, 1);
    pulse_done();
    wait_idle("drop");
    chk("drop_pulses", drop_cnt - d0, 1);

    // 33 pixels: the extra one sets overflow and is not counted
    clear_pix(); pix[0] = 2'd2; pix[1] = 2'd2; pix[32] = 2'd2;
    push(1, 0, 0, 0, 0); push(2, 0, 0, 1, 2); push(3, 0, 0, 0, 0);
    send_pixels(32);
    chk("ovf_after32", ovf, 0);
    lvalid = 1'b1; label = pix[32];
    @(posedge clk); #1;
    lvalid = 1'b0; label = '0;
    chk("ovf_after33", ovf, 1);
    pulse_done();
    chk("ovf_cleared", ovf, 0);
    wait_idle("ovf");

    // Reset in the middle of DIVIDE clears outputs without a clock edge
    frame_a();
    send_pixels(32); pulse_done();
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", cvalid, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame_a(); push_a();
    send_pixels(32); pulse_done(); wait_idle("post_rst");

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("drop_total", drop_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
